// File: rtl/debug_unit_receive_param_if.sv
// Byte-in / word-out bundle between a UART receiver and the program loader.
// Carries the received byte strobe inward and the assembled memory write outward.
// No backpressure: a byte is consumed on the cycle i_rx_done is high.
interface debug_unit_receive_param_if #(
    parameter int NB_BYTE = 8,
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic [NB_BYTE-1:0] i_rx_data;              // received UART byte
    logic               i_rx_done;              // one-cycle byte-valid strobe
    logic               o_enable_write_memory;  // high while loading a program
    logic               o_done_write_memory;    // one-cycle pulse: word/address valid
    logic [NB_DATA-1:0] o_data_memory;          // assembled word
    logic [NB_ADDR-1:0] o_write_address;        // address of current/last word

    // Byte source side (UART receiver or testbench).
    modport master (
        output i_rx_data, i_rx_done,
        input  o_enable_write_memory, o_done_write_memory, o_data_memory, o_write_address
    );

    // Loader side.
    modport slave (
        input  i_rx_data, i_rx_done,
        output o_enable_write_memory, o_done_write_memory, o_data_memory, o_write_address
    );
endinterface

// File: rtl/debug_unit_receive_param.sv
// Debug-unit command receiver: loads a program word by word over UART, then takes mode/step/abort commands.
// Latency: one clock from the edge sampling i_rx_done=1 to every affected (registered) output.
// Backpressure: none; every strobed byte is consumed, a stalled partial word is discarded by the timeout.
// Ports: i_clock/i_reset (sync, active low); bus = byte input + memory write outputs;
//        o_execution_mode/step/run = execution control; o_load_error = 00 ok/01 timeout/10 overflow/11 bad mode;
//        o_state = IDLE 0, LOAD 1, MODE 2, RUN 3, ERROR 4.
module debug_unit_receive_param #(
    parameter int                   NB_BYTE   = 8,
    parameter int                   NB_DATA   = 32,
    parameter int                   NB_ADDR   = 8,
    parameter int                   NB_STATE  = 3,
    parameter logic [NB_BYTE-1:0]   CMD_LOAD  = 8'h55,
    parameter logic [NB_BYTE-1:0]   CMD_STEP  = 8'h01,
    parameter logic [NB_BYTE-1:0]   CMD_ABORT = 8'hA5,
    parameter logic [NB_DATA-1:0]   HALT_WORD = '1,
    parameter int                   N_TIMEOUT = 1000000
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    debug_unit_receive_param_if.slave   bus,
    output logic                        o_execution_mode,
    output logic                        o_execution_step,
    output logic                        o_execution_run,
    output logic [1:0]                  o_load_error,
    output logic [NB_STATE-1:0]         o_state
);
    localparam int                 BPW       = NB_DATA / NB_BYTE;
    localparam int                 NB_CNT    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(BPW - 1);
    localparam logic [NB_ADDR-1:0] ADDR_MAX  = '1;
    localparam logic [31:0]        TMO_LAST  = 32'(N_TIMEOUT - 1);
    localparam logic [NB_BYTE-1:0] MODE_STEP = NB_BYTE'(1);
    localparam logic [NB_BYTE-1:0] MODE_CONT = NB_BYTE'(0);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_BAD_MODE = 2'b11;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = NB_STATE'(0),
        ST_LOAD  = NB_STATE'(1),
        ST_MODE  = NB_STATE'(2),
        ST_RUN   = NB_STATE'(3),
        ST_ERROR = NB_STATE'(4)
    } state_t;

    state_t             r_state, w_state_n;
    logic [NB_CNT-1:0]  r_cnt, w_cnt_n;
    logic [NB_DATA-1:0] r_shift, w_shift_n;
    logic [31:0]        r_timer, w_timer_n;
    logic [NB_ADDR-1:0] r_addr, w_addr_n;
    logic               r_inc_pending, w_inc_n;
    logic [NB_DATA-1:0] r_data, w_data_n;
    logic               r_done, w_done_n;
    logic               r_en;
    logic               r_mode, w_mode_n;
    logic               r_step, w_step_n;
    logic               r_run, w_run_n;
    logic [1:0]         r_err, w_err_n;

    logic [NB_DATA-1:0] w_shift_cat;
    logic [NB_ADDR-1:0] w_addr_cur;
    logic               w_byte;

    assign w_byte      = bus.i_rx_done;
    // MSB-first: earlier bytes migrate toward the top of the word.
    assign w_shift_cat = (r_shift << NB_BYTE) | NB_DATA'(bus.i_rx_data);
    // Address advances the cycle after a done pulse, so the pending increment
    // is folded in here; a word completing on that very cycle sees the new address.
    assign w_addr_cur  = r_addr + NB_ADDR'(r_inc_pending);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_shift_n = r_shift;
        w_timer_n = r_timer;
        w_addr_n  = w_addr_cur;
        w_inc_n   = 1'b0;
        w_data_n  = r_data;
        w_done_n  = 1'b0;
        w_mode_n  = r_mode;
        w_step_n  = 1'b0;
        w_run_n   = r_run;
        w_err_n   = r_err;

        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (w_byte) begin
                    if (bus.i_rx_data == CMD_LOAD) begin
                        w_state_n = ST_LOAD;
                        w_addr_n  = '0;
                        w_cnt_n   = '0;
                        w_shift_n = '0;
                        w_timer_n = '0;
                        w_err_n   = ERR_NONE;
                        w_mode_n  = 1'b0;
                        w_run_n   = 1'b0;
                    end else if (r_state == ST_ERROR && bus.i_rx_data == CMD_ABORT) begin
                        w_state_n = ST_IDLE;
                        w_mode_n  = 1'b0;
                        w_run_n   = 1'b0;
                    end
                end
            end

            ST_LOAD: begin
                // Command values are plain data here; only the timeout leaves LOAD early.
                if (w_byte) begin
                    w_shift_n = w_shift_cat;
                    w_timer_n = '0;
                    if (r_cnt == LAST_BYTE) begin
                        w_cnt_n  = '0;
                        w_data_n = w_shift_cat;
                        w_done_n = 1'b1;
                        if (w_shift_cat == HALT_WORD) begin
                            w_state_n = ST_MODE;
                        end else if (w_addr_cur == ADDR_MAX) begin
                            // Last slot written; no wrap-around.
                            w_state_n = ST_ERROR;
                            w_err_n   = ERR_OVERFLOW;
                        end else begin
                            w_inc_n = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + NB_CNT'(1);
                    end
                end else if (N_TIMEOUT != 0 && r_cnt != '0) begin
                    // Timer only runs while a word is partially assembled.
                    if (r_timer == TMO_LAST) begin
                        w_state_n = ST_ERROR;
                        w_err_n   = ERR_TIMEOUT;
                        w_cnt_n   = '0;
                        w_shift_n = '0;
                        w_timer_n = '0;
                    end else begin
                        w_timer_n = r_timer + 32'd1;
                    end
                end
            end

            ST_MODE: begin
                if (w_byte) begin
                    if (bus.i_rx_data == CMD_ABORT) begin
                        w_state_n = ST_IDLE;
                        w_mode_n  = 1'b0;
                        w_run_n   = 1'b0;
                    end else if (bus.i_rx_data == MODE_STEP) begin
                        w_state_n = ST_RUN;
                        w_mode_n  = 1'b1;
                        w_run_n   = 1'b1;
                    end else if (bus.i_rx_data == MODE_CONT) begin
                        w_state_n = ST_RUN;
                        w_mode_n  = 1'b0;
                        w_run_n   = 1'b1;
                    end else begin
                        w_state_n = ST_ERROR;
                        w_err_n   = ERR_BAD_MODE;
                    end
                end
            end

            ST_RUN: begin
                if (w_byte) begin
                    if (bus.i_rx_data == CMD_ABORT) begin
                        w_state_n = ST_IDLE;
                        w_mode_n  = 1'b0;
                        w_run_n   = 1'b0;
                    end else if (r_mode && bus.i_rx_data == CMD_STEP) begin
                        w_step_n = 1'b1;
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_timer       <= '0;
            r_addr        <= '0;
            r_inc_pending <= 1'b0;
            r_data        <= '0;
            r_done        <= 1'b0;
            r_en          <= 1'b0;
            r_mode        <= 1'b0;
            r_step        <= 1'b0;
            r_run         <= 1'b0;
            r_err         <= ERR_NONE;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_shift       <= w_shift_n;
            r_timer       <= w_timer_n;
            r_addr        <= w_addr_n;
            r_inc_pending <= w_inc_n;
            r_data        <= w_data_n;
            r_done        <= w_done_n;
            r_en          <= (w_state_n == ST_LOAD);
            r_mode        <= w_mode_n;
            r_step        <= w_step_n;
            r_run         <= w_run_n;
            r_err         <= w_err_n;
        end
    end

    assign bus.o_enable_write_memory = r_en;
    assign bus.o_done_write_memory   = r_done;
    assign bus.o_data_memory         = r_data;
    assign bus.o_write_address       = r_addr;
    assign o_execution_mode          = r_mode;
    assign o_execution_step          = r_step;
    assign o_execution_run           = r_run;
    assign o_load_error              = r_err;
    assign o_state                   = r_state;
endmodule

// File: tb/tb_debug_unit_receive_param.sv
// Bench for debug_unit_receive_param: instance A (32-bit words, 4-word program, timeout 10)
// checked every cycle against a transaction-level model; instance B (16-bit words) directed.
module tb_debug_unit_receive_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b;
    int checks = 0;
    int errors = 0;

    debug_unit_receive_param_if #(.NB_BYTE(8), .NB_DATA(32), .NB_ADDR(2)) if_a ();
    debug_unit_receive_param_if #(.NB_BYTE(8), .NB_DATA(16), .NB_ADDR(8)) if_b ();

    logic       mode_a, step_a, run_a, mode_b, step_b, run_b;
    logic [1:0] err_a, err_b;
    logic [2:0] st_a, st_b;

    debug_unit_receive_param #(.NB_ADDR(2), .N_TIMEOUT(10)) dut_a (
        .i_clock(clk), .i_reset(rst_n_a), .bus(if_a),
        .o_execution_mode(mode_a), .o_execution_step(step_a), .o_execution_run(run_a),
        .o_load_error(err_a), .o_state(st_a)
    );

    debug_unit_receive_param #(.NB_DATA(16)) dut_b (
        .i_clock(clk), .i_reset(rst_n_b), .bus(if_b),
        .o_execution_mode(mode_b), .o_execution_step(step_b), .o_execution_run(run_b),
        .o_load_error(err_b), .o_state(st_b)
    );

    // Reference model for A, kept as program-loader bookkeeping:
    // words collected so far, bytes of the current word, idle clocks since last byte.
    int          m_state, m_cnt, m_idle, m_addr;
    bit          m_pend, m_done, m_mode, m_step, m_run;
    logic [31:0] m_word, m_data;
    int          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_idle = 0; m_addr = 0; m_pend = 0; m_done = 0;
        m_mode = 0; m_step = 0; m_run = 0; m_word = '0; m_data = '0; m_err = 0;
    endtask

    task automatic model_cycle(input bit has, input logic [7:0] b);
        logic [31:0] w;
        if (m_pend) begin m_addr = m_addr + 1; m_pend = 0; end
        m_done = 0; m_step = 0;
        case (m_state)
            0, 4: if (has) begin
                if (b == 8'h55) begin
                    m_state = 1; m_addr = 0; m_cnt = 0; m_word = '0; m_idle = 0; m_err = 0;
                end else if (b == 8'hA5 && m_state == 4) begin
                    m_state = 0; m_mode = 0; m_run = 0;
                end
            end
            1: if (has) begin
                w = {m_word[23:0], b};
                m_word = w; m_cnt++; m_idle = 0;
                if (m_cnt == 4) begin
                    m_cnt = 0; m_data = w; m_done = 1;
                    if (w == 32'hFFFF_FFFF) m_state = 2;
                    else if (m_addr == 3) begin m_state = 4; m_err = 2; end
                    else m_pend = 1;
                end
            end else if (m_cnt != 0) begin
                m_idle++;
                if (m_idle == 10) begin
                    m_state = 4; m_err = 1; m_cnt = 0; m_word = '0; m_idle = 0;
                end
            end
            2: if (has) begin
                if (b == 8'hA5) begin m_state = 0; m_mode = 0; m_run = 0; end
                else if (b == 8'h01) begin m_state = 3; m_mode = 1; m_run = 1; end
                else if (b == 8'h00) begin m_state = 3; m_mode = 0; m_run = 1; end
                else begin m_state = 4; m_err = 3; end
            end
            3: if (has) begin
                if (b == 8'hA5) begin m_state = 0; m_mode = 0; m_run = 0; end
                else if (m_mode && b == 8'h01) m_step = 1;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_a();
        chk("a_state", 32'(st_a), m_state);
        chk("a_enable", 32'(if_a.o_enable_write_memory), 32'(m_state == 1));
        chk("a_done", 32'(if_a.o_done_write_memory), 32'(m_done));
        chk("a_data", if_a.o_data_memory, m_data);
        chk("a_addr", 32'(if_a.o_write_address), m_addr);
        chk("a_mode", 32'(mode_a), 32'(m_mode));
        chk("a_step", 32'(step_a), 32'(m_step));
        chk("a_run", 32'(run_a), 32'(m_run));
        chk("a_err", 32'(err_a), m_err);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic cyc_a(input bit has, input logic [7:0] b);
        if_a.i_rx_done = has;
        if_a.i_rx_data = has ? b : 8'($urandom);
        model_cycle(has, b);
        @(negedge clk);
        check_a();
    endtask

    task automatic send_a(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) cyc_a(1'b1, w[8*k +: 8]);
    endtask

    task automatic reset_a();
        rst_n_a = 1'b0;
        if_a.i_rx_done = 1'($urandom_range(0, 1));
        if_a.i_rx_data = 8'h55;
        model_reset();
        @(negedge clk);
        check_a();
        rst_n_a = 1'b1;
    endtask

    task automatic cyc_b(input bit has, input logic [7:0] b);
        if_b.i_rx_done = has;
        if_b.i_rx_data = b;
        @(negedge clk);
    endtask

    task automatic check_b_zero(input string tag);
        chk({tag, "_state"}, 32'(st_b), 0);
        chk({tag, "_en"}, 32'(if_b.o_enable_write_memory), 0);
        chk({tag, "_done"}, 32'(if_b.o_done_write_memory), 0);
        chk({tag, "_data"}, 32'(if_b.o_data_memory), 0);
        chk({tag, "_addr"}, 32'(if_b.o_write_address), 0);
        chk({tag, "_ctl"}, {27'd0, mode_b, step_b, run_b, err_b}, 0);
    endtask

    initial begin
        int          r, g;
        logic [7:0]  rb;
        rst_n_b = 1'b0;
        if_b.i_rx_done = 1'b0;
        if_b.i_rx_data = 8'h00;
        reset_a();
        rst_n_b = 1'b1;
        check_b_zero("b_reset");

        // Two data words then halt, step mode, three back-to-back steps.
        cyc_a(1, 8'h55);
        chk("a_load_enable", 32'(if_a.o_enable_write_memory), 1);
        send_a(32'hAABB_CCDD);
        chk("a_word0_data", if_a.o_data_memory, 32'hAABB_CCDD);
        chk("a_word0_addr", 32'(if_a.o_write_address), 0);
        send_a(32'h1122_3344);
        chk("a_word1_addr", 32'(if_a.o_write_address), 1);
        send_a(32'hFFFF_FFFF);
        chk("a_halt_addr", 32'(if_a.o_write_address), 2);
        chk("a_halt_done", 32'(if_a.o_done_write_memory), 1);
        cyc_a(1, 8'h01);
        chk("a_mode_state", 32'(st_a), 3);
        for (int k = 0; k < 3; k++) begin
            cyc_a(1, 8'h01);
            chk("a_step_pulse", 32'(step_a), 1);
        end
        cyc_a(0, 0); cyc_a(0, 0);
        cyc_a(1, 8'hA5);

        // Overflow: four non-halt words fill a 4-word program.
        cyc_a(1, 8'h55);
        send_a(32'h0102_0304); send_a(32'h0506_0708);
        send_a(32'h55A5_5501); send_a(32'hDEAD_BEEF);
        chk("a_ovf_addr", 32'(if_a.o_write_address), 3);
        chk("a_ovf_err", 32'(err_a), 2);
        cyc_a(1, 8'h55);
        chk("a_reload_err", 32'(err_a), 0);

        // Timeout on a partial word.
        cyc_a(1, 8'hAA); cyc_a(1, 8'hBB);
        for (int k = 0; k < 12; k++) cyc_a(0, 0);
        chk("a_tmo_state", 32'(st_a), 4);
        chk("a_tmo_err", 32'(err_a), 1);

        // Bad mode byte, abort, continuous run ignores step bytes.
        cyc_a(1, 8'h55); send_a(32'hFFFF_FFFF); cyc_a(1, 8'h07);
        chk("a_badmode_err", 32'(err_a), 3);
        cyc_a(1, 8'hA5);
        chk("a_abort_state", 32'(st_a), 0);
        cyc_a(1, 8'h55); send_a(32'hFFFF_FFFF); cyc_a(1, 8'h00);
        chk("a_cont_run", 32'(run_a), 1);
        cyc_a(1, 8'h01); cyc_a(1, 8'h01);
        cyc_a(1, 8'hA5);

        // Random traffic, compared cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                reset_a();
            end else if (r < 14) begin
                send_a(32'hFFFF_FFFF);
            end else if (r < 24) begin
                g = int'($urandom_range(1, 14));
                for (int k = 0; k < g; k++) cyc_a(0, 0);
            end else begin
                case ($urandom_range(0, 5))
                    0: rb = 8'h55;
                    1: rb = 8'hA5;
                    2: rb = 8'h01;
                    3: rb = 8'h00;
                    default: rb = 8'($urandom);
                endcase
                cyc_a(1, rb);
            end
        end
        if_a.i_rx_done = 1'b0;

        // 16-bit words: two bytes per word, then reset mid-word.
        cyc_b(1, 8'h55);
        chk("b_load_state", 32'(st_b), 1);
        cyc_b(1, 8'h12); cyc_b(1, 8'h34);
        chk("b_word_done", 32'(if_b.o_done_write_memory), 1);
        chk("b_word_data", 32'(if_b.o_data_memory), 32'h1234);
        chk("b_word_addr", 32'(if_b.o_write_address), 0);
        cyc_b(0, 8'h00);
        chk("b_addr_next", 32'(if_b.o_write_address), 1);
        cyc_b(1, 8'h56);
        rst_n_b = 1'b0;
        cyc_b(1, 8'h78);
        check_b_zero("b_midword_reset");
        rst_n_b = 1'b1;
        cyc_b(1, 8'h12); cyc_b(1, 8'h34);
        cyc_b(0, 8'h00);
        check_b_zero("b_idle_ignore");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
